ram64_arbiter: RTL and testbench

- Sequences and shares the 64-word x 16-bit Ram64 between two requesters: requester 0 is the CPU datapath; requester 1 is the button/debug port.
- Owns all Ram64 control inputs (in, load, address).
- After reset, optionally sweeps the RAM to zero.
- Then arbitrates single-word read/write transactions round-robin, using a req/ack handshake.

---
 rtl/ram64_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram64_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram64_arbiter.sv
// ---------------------------------------------------------------------------
// ram64_arbiter
//
// Purpose:
//   Owns the control inputs of a 64-word x 16-bit RAM (combinational read,
//   write on the rising edge when load is high). It shares the RAM between
//   two requesters: requester 0 is the CPU datapath and requester 1 is the
//   button/debug port. After reset the arbiter can zero every word. It then
//   serves single-word read or write transactions in round-robin order,
//   using a req/ack handshake.
//
//   A transaction takes a grant edge in IDLE, one ACCESS cycle and one RESP
//   cycle in which ack is high. The read data is captured at the end of
//   ACCESS. A write therefore returns the word's previous contents
//   (exchange semantics).
//
// Ports:
//   Clock, Reset          clock and synchronous active-high reset
//   r0_req/we/addr/wdata  requester 0 transaction request
//   r0_ack, r0_rdata      requester 0 completion pulse and read result
//   r1_*                  same as r0_*, for requester 1
//   ram_in, ram_load,     RAM data, write strobe and address (registered)
//   ram_addr
//   ram_out               RAM combinational read of ram_addr
//   busy                  clear sweep or transaction in progress
//
// DEPTH must equal 2**ADDR_W.
// ---------------------------------------------------------------------------
module ram64_arbiter #(
    parameter int   DATA_W         = 16,
    parameter int   ADDR_W         = 6,
    parameter int   DEPTH          = 64,
    parameter logic CLEAR_ON_RESET = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,

    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_out,

    output logic              busy
);

    // The state register names the action taken at the next rising edge.
    // All RAM-facing outputs are registers, so the outputs visible in a
    // cycle are the ones set up by the previous edge. For example, the last
    // sweep write (address DEPTH-1) is visible while the state already
    // reads IDLE. This lets a request pending during the sweep be granted
    // on the edge that ends the sweep.
    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W:0]   clr_cnt;
    logic              last_grant;   // 0 = requester 0 served last, 1 = requester 1

    logic              grant0;
    logic              grant1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Round-robin decode: on a tie, the requester that did not win last time is served.
    always_comb begin
        grant0    = r0_req && (!r1_req || last_grant);
        grant1    = r1_req && (!r0_req || !last_grant);
        sel_we    = grant1 ? r1_we    : r0_we;
        sel_addr  = grant1 ? r1_addr  : r0_addr;
        sel_wdata = grant1 ? r1_wdata : r0_wdata;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt    <= '0;
            last_grant <= 1'b1;
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
            ram_load   <= 1'b0;
            ram_addr   <= '0;
            ram_in     <= '0;
            busy       <= CLEAR_ON_RESET;
        end else begin
            // Acks are single-cycle pulses unless ACCESS sets one below.
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;

            case (state)
                ST_CLEAR: begin
                    // Issue one zero write per cycle. The edge that issues
                    // the last address moves to IDLE. busy stays high so it
                    // covers exactly DEPTH write cycles.
                    ram_load <= 1'b1;
                    ram_in   <= '0;
                    ram_addr <= clr_cnt[ADDR_W-1:0];
                    clr_cnt  <= clr_cnt + 1'b1;
                    busy     <= 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        // The RAM-facing registers double as the latched
                        // request. They stay stable through ACCESS.
                        ram_load   <= sel_we;
                        ram_addr   <= sel_addr;
                        ram_in     <= sel_wdata;
                        last_grant <= grant1;
                        busy       <= 1'b1;
                        state      <= ST_ACCESS;
                    end else begin
                        ram_load <= 1'b0;
                        busy     <= 1'b0;
                    end
                end

                ST_ACCESS: begin
                    // ram_out still shows the pre-write word. The RAM
                    // updates on this same edge.
                    if (last_grant) begin
                        r1_rdata <= ram_out;
                        r1_ack   <= 1'b1;
                    end else begin
                        r0_rdata <= ram_out;
                        r0_ack   <= 1'b1;
                    end
                    ram_load <= 1'b0;
                    busy     <= 1'b1;
                    state    <= ST_RESP;
                end

                default: begin
                    // ST_RESP: the ack cycle ends here. ram_addr and ram_in
                    // keep their last values.
                    ram_load <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram64_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram64_arbiter
//
// Directed bench for ram64_arbiter. It contains a behavioural 64x16 RAM:
// combinational read, write on the rising edge when load is high, and a
// preload of 0xFFFF during the first reset edge. The bench drives inputs
// and samples outputs 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_ram64_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [5:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;
    logic        r0_ack, r1_ack;
    logic [15:0] r0_rdata, r1_rdata;
    logic [15:0] ram_in, ram_out;
    logic        ram_load;
    logic [5:0]  ram_addr;
    logic        busy;

    logic [15:0] mem [64];
    logic        preload;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    ram64_arbiter #(
        .DATA_W(16), .ADDR_W(6), .DEPTH(64), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .ram_in(ram_in), .ram_load(ram_load), .ram_addr(ram_addr), .ram_out(ram_out),
        .busy(busy)
    );

    always @(posedge Clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'hFFFF;
        end else if (ram_load === 1'b1) begin
            mem[ram_addr] <= ram_in;
        end
    end
    assign ram_out = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Starts in the cycle in which Reset was released. Counts the
    // consecutive load cycles and checks address order, zero data, busy,
    // and that no ack appears.
    task automatic sweep_check(input string tag);
        int n;
        int errs;
        n    = 0;
        errs = 0;
        step();
        while (ram_load === 1'b1 && n < 200) begin
            if (ram_addr !== n[5:0] || ram_in !== 16'h0000 || busy !== 1'b1 ||
                r0_ack !== 1'b0 || r1_ack !== 1'b0) errs++;
            n++;
            step();
        end
        check({tag, "_len"}, 32'(n), 32'd64);
        check({tag, "_seq"}, 32'(errs), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; preload = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        // r1 asks to read address 63 before and during the sweep.
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 6'd63; r1_wdata = '0;

        // Reset values
        step(); preload = 1'b0;
        step(); step();
        check("rst_r0_ack",   32'(r0_ack),   32'd0);
        check("rst_r1_ack",   32'(r1_ack),   32'd0);
        check("rst_r0_rdata", 32'(r0_rdata), 32'd0);
        check("rst_r1_rdata", 32'(r1_rdata), 32'd0);
        check("rst_load",     32'(ram_load), 32'd0);
        check("rst_addr",     32'(ram_addr), 32'd0);
        check("rst_in",       32'(ram_in),   32'd0);
        check("rst_busy",     32'(busy),     32'd1);

        // Clear sweep; r1 is served on the edge that ends it
        Reset = 1'b0;
        sweep_check("clr1");
        check("r1_access_busy", 32'(busy),     32'd1);
        check("r1_access_addr", 32'(ram_addr), 32'd63);
        check("r1_access_ack",  32'(r1_ack),   32'd0);
        step();
        check("r1_sweep_ack",   32'(r1_ack),   32'd1);
        check("r1_sweep_rdata", 32'(r1_rdata), 32'h0000);
        r1_req = 1'b0;
        step();
        check("r1_ack_drop", 32'(r1_ack), 32'd0);
        check("idle_busy",   32'(busy),   32'd0);

        // r0 writes 0xBEEF to 0x12 (gets the old 0x0000)
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 6'h12; r0_wdata = 16'hBEEF;
        step();
        check("wr_load", 32'(ram_load), 32'd1);
        check("wr_addr", 32'(ram_addr), 32'h12);
        check("wr_in",   32'(ram_in),   32'hBEEF);
        step();
        check("wr_ack",   32'(r0_ack),   32'd1);
        check("wr_rdata", 32'(r0_rdata), 32'h0000);
        r0_req = 1'b0; r0_we = 1'b0;
        step();
        check("wr_ack_drop", 32'(r0_ack), 32'd0);

        // r0 reads 0x12 back
        r0_req = 1'b1; r0_addr = 6'h12;
        step();
        check("rd_load", 32'(ram_load), 32'd0);
        step();
        check("rd_ack",   32'(r0_ack),   32'd1);
        check("rd_rdata", 32'(r0_rdata), 32'hBEEF);
        r0_req = 1'b0;
        step();

        // r1 writes 0x1357 to 0x05, which makes r1 the last winner
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 6'h05; r1_wdata = 16'h1357;
        step(); step();
        check("r1wr_ack",    32'(r1_ack),   32'd1);
        check("r1wr_rdata",  32'(r1_rdata), 32'h0000);
        check("r0_rdata_hold", 32'(r0_rdata), 32'hBEEF);
        r1_req = 1'b0; r1_we = 1'b0;
        step();

        // Tie: r0 reads 0x3F and r1 reads 0x12, both held
        r0_req = 1'b1; r0_addr = 6'h3F;
        r1_req = 1'b1; r1_addr = 6'h12;
        step();
        check("tie1_addr", 32'(ram_addr), 32'h3F);
        step();
        check("tie1_r0_ack",   32'(r0_ack),   32'd1);
        check("tie1_r1_ack",   32'(r1_ack),   32'd0);
        check("tie1_r0_rdata", 32'(r0_rdata), 32'h0000);
        step();
        check("tie_gap_busy", 32'(busy), 32'd0);
        step();
        check("tie2_addr", 32'(ram_addr), 32'h12);
        step();
        check("tie2_r1_ack",   32'(r1_ack),   32'd1);
        check("tie2_r0_ack",   32'(r0_ack),   32'd0);
        check("tie2_r1_rdata", 32'(r1_rdata), 32'hBEEF);
        step(); step();
        check("tie3_addr", 32'(ram_addr), 32'h3F);
        step();
        check("tie3_r0_ack", 32'(r0_ack), 32'd1);
        check("tie3_r1_ack", 32'(r1_ack), 32'd0);
        r0_req = 1'b0; r1_req = 1'b0;
        step();

        // r0 holds req through its ack: a second transaction follows 3 cycles later
        r0_req = 1'b1; r0_addr = 6'h12;
        step(); step();
        check("hold_ack1",   32'(r0_ack),   32'd1);
        check("hold_rdata1", 32'(r0_rdata), 32'hBEEF);
        step();
        check("hold_gap", 32'(r0_ack), 32'd0);
        step();
        check("hold_access_busy", 32'(busy), 32'd1);
        step();
        check("hold_ack2", 32'(r0_ack), 32'd1);
        r0_req = 1'b0;
        step();

        // Reset lands in the ACCESS cycle of an r0 write
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 6'h20; r0_wdata = 16'h1234;
        step();
        check("rstw_load", 32'(ram_load), 32'd1);
        Reset = 1'b1; r0_req = 1'b0; r0_we = 1'b0;
        step();
        check("rstw_no_ack", 32'(r0_ack),   32'd0);
        check("rstw_rdata",  32'(r0_rdata), 32'h0000);
        check("rstw_busy",   32'(busy),     32'd1);
        check("rstw_load0",  32'(ram_load), 32'd0);
        step();
        check("rstw_no_ack2", 32'(r0_ack), 32'd0);
        Reset = 1'b0;
        sweep_check("clr2");
        check("clr2_busy", 32'(busy), 32'd0);

        // After reset r0 wins the first tie again
        r0_req = 1'b1; r0_addr = 6'h12;
        r1_req = 1'b1; r1_addr = 6'h05;
        step();
        check("tie_rst_addr", 32'(ram_addr), 32'h12);
        step();
        check("tie_rst_r0_ack", 32'(r0_ack),   32'd1);
        check("tie_rst_r1_ack", 32'(r1_ack),   32'd0);
        check("tie_rst_rdata",  32'(r0_rdata), 32'h0000);
        r0_req = 1'b0; r1_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
